// File: rtl/score_board_mp_pkg.sv
// Shared constants and types for the multi-port register scoreboard.
package score_board_mp_pkg;

  localparam int             SB_POS_W    = 5;
  localparam int             SB_FU_W     = 3;
  localparam logic [4:0]     SB_FWD_MASK = 5'b00011;

  typedef logic bool_t;

  typedef struct packed {
    logic [SB_FU_W-1:0]  fu;
    logic [SB_POS_W-1:0] pos;
  } sb_entry_t;

endpackage

// File: rtl/score_board_mp_if.sv
// Issue-stage scoreboard bus: claim/flush controls in, per-source lookups out.
interface score_board_mp_if
  import score_board_mp_pkg::*;
#(
  parameter int REG_NUM     = 32,
  parameter int WRITE_PORTS = 2,
  parameter int READ_PORTS  = 4,
  parameter int POS_W       = SB_POS_W,
  parameter int FU_W        = SB_FU_W
);
  localparam int AW = $clog2(REG_NUM);

  logic                               stall;
  logic                               flash;
  logic [POS_W-1:0]                   kill_mask;
  logic [WRITE_PORTS-1:0]             write_ena;
  logic [WRITE_PORTS-1:0][AW-1:0]     write_addr;
  logic [WRITE_PORTS-1:0][FU_W-1:0]   write_fu;
  logic [WRITE_PORTS-1:0][POS_W-1:0]  write_pos;
  logic [READ_PORTS-1:0][AW-1:0]      read_addr;
  logic [READ_PORTS-1:0][FU_W-1:0]    read_fu;
  logic [READ_PORTS-1:0][POS_W-1:0]   read_pos;
  logic [READ_PORTS-1:0]              read_pending;
  logic [READ_PORTS-1:0]              read_stall;
  logic [AW:0]                        busy_count;

  modport master (
    output stall, flash, kill_mask, write_ena, write_addr, write_fu, write_pos, read_addr,
    input  read_fu, read_pos, read_pending, read_stall, busy_count
  );

  modport slave (
    input  stall, flash, kill_mask, write_ena, write_addr, write_fu, write_pos, read_addr,
    output read_fu, read_pos, read_pending, read_stall, busy_count
  );
endinterface

// File: rtl/score_board_mp_sb_entry.sv
// One scoreboard entry: a producing-unit tag plus a one-hot distance-to-writeback
// field that shifts toward zero, with flush/kill clearing and claim loading.
module sb_entry
  import score_board_mp_pkg::*;
#(
  parameter int POS_W = SB_POS_W,
  parameter int FU_W  = SB_FU_W
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             load,
  input  logic [FU_W-1:0]  load_fu,
  input  logic [POS_W-1:0] load_pos,
  input  logic             clear,
  input  logic [POS_W-1:0] kill_mask,
  output logic [FU_W-1:0]  fu,
  output logic [POS_W-1:0] pos,
  output logic [POS_W-1:0] pos_nxt
);
  logic [FU_W-1:0]  fu_d,  fu_q;
  logic [POS_W-1:0] pos_d, pos_q;

  // The caller only raises load on a plain update cycle, so kill never meets load.
  always_comb begin
    fu_d  = fu_q;
    pos_d = pos_q;
    if (clear || (|(pos_q & kill_mask))) begin
      fu_d  = '0;
      pos_d = '0;
    end else if (load) begin
      fu_d  = load_fu;
      pos_d = load_pos;
    end else if (shift_en) begin
      pos_d = pos_q >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fu_q  <= '0;
      pos_q <= '0;
    end else begin
      fu_q  <= fu_d;
      pos_q <= pos_d;
    end
  end

  assign fu      = fu_q;
  assign pos     = pos_q;
  assign pos_nxt = pos_d;

endmodule

// File: rtl/score_board_mp.sv
// Multi-port register scoreboard: per-register pending-result tracking with
// write claims, partial/full flush, same-cycle bypass and per-port RAW stall.
module score_board_mp
  import score_board_mp_pkg::*;
#(
  parameter int               REG_NUM     = 32,
  parameter int               WRITE_PORTS = 2,
  parameter int               READ_PORTS  = 4,
  parameter int               POS_W       = SB_POS_W,
  parameter int               FU_W        = SB_FU_W,
  parameter logic [POS_W-1:0] FWD_MASK    = POS_W'(SB_FWD_MASK),
  parameter bit               BYPASS      = 1'b1
)(
  input  logic               clk,
  input  logic               rst_n,
  score_board_mp_if.slave    sb
);
  localparam int AW = $clog2(REG_NUM);

  logic                 upd;
  logic [REG_NUM-1:1]   load;
  logic [FU_W-1:0]      load_fu  [1:REG_NUM-1];
  logic [POS_W-1:0]     load_pos [1:REG_NUM-1];
  logic [POS_W-1:0]     nxt_pos  [1:REG_NUM-1];
  logic [FU_W-1:0]      ent_fu   [REG_NUM];
  logic [POS_W-1:0]     ent_pos  [REG_NUM];
  logic [AW:0]          busy_count_d, busy_count_q;

  // Claims and bypass only happen on a plain update cycle.
  assign upd = rst_n & ~sb.stall & ~sb.flash & ~(|sb.kill_mask);

  always_comb begin
    for (int r = 1; r < REG_NUM; r++) begin
      load[r]     = 1'b0;
      load_fu[r]  = '0;
      load_pos[r] = '0;
      // Ascending slot order lets the highest slot win an address collision.
      for (int s = 0; s < WRITE_PORTS; s++) begin
        if (upd && sb.write_ena[s] && (sb.write_addr[s] == AW'(r))) begin
          load[r]     = 1'b1;
          load_fu[r]  = sb.write_fu[s];
          load_pos[r] = sb.write_pos[s];
        end
      end
    end
  end

  assign ent_fu[0]  = '0;
  assign ent_pos[0] = '0;

  for (genvar i = 1; i < REG_NUM; i++) begin : g_ent
    sb_entry #(
      .POS_W (POS_W),
      .FU_W  (FU_W)
    ) u_entry (
      .clk       (clk),
      .rst_n     (rst_n),
      .shift_en  (~sb.stall),
      .load      (load[i]),
      .load_fu   (load_fu[i]),
      .load_pos  (load_pos[i]),
      .clear     (sb.flash),
      .kill_mask (sb.kill_mask),
      .fu        (ent_fu[i]),
      .pos       (ent_pos[i]),
      .pos_nxt   (nxt_pos[i])
    );
  end

  always_comb begin
    for (int p = 0; p < READ_PORTS; p++) begin
      sb.read_fu[p]  = ent_fu[sb.read_addr[p]];
      sb.read_pos[p] = ent_pos[sb.read_addr[p]];
      if (BYPASS && upd) begin
        for (int s = 0; s < WRITE_PORTS; s++) begin
          if (sb.write_ena[s] && (sb.write_addr[s] == sb.read_addr[p])) begin
            sb.read_fu[p]  = sb.write_fu[s];
            sb.read_pos[p] = sb.write_pos[s];
          end
        end
      end
      if (sb.read_addr[p] == '0) begin
        sb.read_fu[p]  = '0;
        sb.read_pos[p] = '0;
      end
      sb.read_pending[p] = |sb.read_pos[p];
      sb.read_stall[p]   = |(sb.read_pos[p] & ~FWD_MASK);
    end
  end

  always_comb begin
    busy_count_d = '0;
    for (int r = 1; r < REG_NUM; r++) begin
      busy_count_d = busy_count_d + (AW+1)'(|nxt_pos[r]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_count_q <= '0;
    else        busy_count_q <= busy_count_d;
  end

  assign sb.busy_count = busy_count_q;

endmodule

// File: tb/tb_score_board_mp.sv
// Randomized and directed bench for score_board_mp against a behavioural model.
module tb_score_board_mp;
  localparam int RN = 32;
  localparam int WP = 2;
  localparam int RP = 4;

  logic clk;
  logic rst_n;
  logic chk_en;
  int   errors;
  int   checks;

  logic [2:0] m_fu  [RN];
  logic [4:0] m_pos [RN];
  int         m_busy;

  score_board_mp_if #(.REG_NUM(RN), .WRITE_PORTS(WP), .READ_PORTS(RP), .POS_W(5), .FU_W(3)) sb_if ();

  score_board_mp #(
    .REG_NUM(RN), .WRITE_PORTS(WP), .READ_PORTS(RP), .POS_W(5), .FU_W(3),
    .FWD_MASK(5'b00011), .BYPASS(1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sb_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic idle();
    sb_if.stall      = 1'b0;
    sb_if.flash      = 1'b0;
    sb_if.kill_mask  = '0;
    sb_if.write_ena  = '0;
    sb_if.write_addr = '0;
    sb_if.write_fu   = '0;
    sb_if.write_pos  = '0;
    sb_if.read_addr  = '0;
  endtask

  task automatic model_reset();
    for (int r = 0; r < RN; r++) begin
      m_fu[r]  = '0;
      m_pos[r] = '0;
    end
    m_busy = 0;
  endtask

  // Next-state rules: flush beats kill beats stall beats a plain shift-plus-claim.
  task automatic model_update();
    if (!rst_n || sb_if.flash) begin
      model_reset();
    end else begin
      if (sb_if.kill_mask != 0) begin
        for (int r = 1; r < RN; r++) begin
          if ((m_pos[r] & sb_if.kill_mask) != 0) begin
            m_fu[r]  = '0;
            m_pos[r] = '0;
          end else if (!sb_if.stall) begin
            m_pos[r] = m_pos[r] >> 1;
          end
        end
      end else if (!sb_if.stall) begin
        for (int r = 1; r < RN; r++) m_pos[r] = m_pos[r] >> 1;
        for (int s = 0; s < WP; s++) begin
          if (sb_if.write_ena[s] && sb_if.write_addr[s] != 0) begin
            m_fu[sb_if.write_addr[s]]  = sb_if.write_fu[s];
            m_pos[sb_if.write_addr[s]] = sb_if.write_pos[s];
          end
        end
      end
      m_busy = 0;
      for (int r = 1; r < RN; r++) if (m_pos[r] != 0) m_busy++;
    end
  endtask

  task automatic model_read(input logic [4:0] a, output logic [2:0] fu, output logic [4:0] pos);
    fu  = m_fu[a];
    pos = m_pos[a];
    if (rst_n && !sb_if.stall && !sb_if.flash && sb_if.kill_mask == 0) begin
      for (int s = 0; s < WP; s++) begin
        if (sb_if.write_ena[s] && sb_if.write_addr[s] == a) begin
          fu  = sb_if.write_fu[s];
          pos = sb_if.write_pos[s];
        end
      end
    end
    if (a == 0) begin
      fu  = '0;
      pos = '0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int p = 0; p < RP; p++) begin
        logic [2:0] efu;
        logic [4:0] epos;
        model_read(sb_if.read_addr[p], efu, epos);
        chk($sformatf("read_fu[%0d]", p),      sb_if.read_fu[p],      efu);
        chk($sformatf("read_pos[%0d]", p),     sb_if.read_pos[p],     epos);
        chk($sformatf("read_pending[%0d]", p), sb_if.read_pending[p], (epos != 0));
        chk($sformatf("read_stall[%0d]", p),   sb_if.read_stall[p],   ((epos & 5'b11100) != 0));
      end
      chk("busy_count", sb_if.busy_count, m_busy);
    end
  end

  initial begin
    errors = 0;
    checks = 0;
    chk_en = 1'b0;
    rst_n  = 1'b0;
    idle();
    model_reset();
    sb_if.read_addr[0] = 5'd5;
    #1;
    chk("reset busy", sb_if.busy_count, 0);
    chk("reset pending", sb_if.read_pending[0], 0);
    chk("reset pos", sb_if.read_pos[0], 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Countdown of a single result.
    idle();
    sb_if.write_ena[0] = 1'b1; sb_if.write_addr[0] = 5'd5;
    sb_if.write_fu[0] = 3'd2;  sb_if.write_pos[0] = 5'b10000;
    step(); idle(); sb_if.read_addr[0] = 5'd5; #1;
    chk("t1 pos", sb_if.read_pos[0], 5'b10000);
    chk("t1 fu", sb_if.read_fu[0], 3'd2);
    chk("t1 stall hi", sb_if.read_stall[0], 1);
    step(); step(); step(); #1;
    chk("t1 pos fwd", sb_if.read_pos[0], 5'b00010);
    chk("t1 stall lo", sb_if.read_stall[0], 0);
    chk("t1 pending", sb_if.read_pending[0], 1);
    step(); #1;
    chk("t1 pending last", sb_if.read_pending[0], 1);
    step(); #1;
    chk("t1 freed", sb_if.read_pending[0], 0);

    // Same-address claims in one cycle.
    idle();
    sb_if.write_ena = 2'b11;
    sb_if.write_addr[0] = 5'd7; sb_if.write_fu[0] = 3'd1; sb_if.write_pos[0] = 5'b00100;
    sb_if.write_addr[1] = 5'd7; sb_if.write_fu[1] = 3'd4; sb_if.write_pos[1] = 5'b01000;
    sb_if.read_addr[1] = 5'd7; #1;
    chk("t2 bypass fu", sb_if.read_fu[1], 3'd4);
    chk("t2 bypass pos", sb_if.read_pos[1], 5'b01000);
    step(); idle(); sb_if.read_addr[1] = 5'd7; #1;
    chk("t2 fu", sb_if.read_fu[1], 3'd4);
    chk("t2 busy", sb_if.busy_count, 1);
    sb_if.flash = 1'b1;
    step(); idle(); #1;
    chk("t2 flash busy", sb_if.busy_count, 0);

    // Stall freezes the countdown.
    sb_if.write_ena[0] = 1'b1; sb_if.write_addr[0] = 5'd3;
    sb_if.write_fu[0] = 3'd5;  sb_if.write_pos[0] = 5'b00100;
    step(); idle(); sb_if.read_addr[2] = 5'd3; sb_if.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      chk("t3 held", sb_if.read_pos[2], 5'b00100);
    end
    sb_if.stall = 1'b0;
    step(); step(); #1;
    chk("t3 pending", sb_if.read_pending[2], 1);
    step(); #1;
    chk("t3 freed", sb_if.read_pending[2], 0);

    // Kill during stall.
    idle();
    sb_if.write_ena = 2'b11;
    sb_if.write_addr[0] = 5'd4; sb_if.write_fu[0] = 3'd1; sb_if.write_pos[0] = 5'b01000;
    sb_if.write_addr[1] = 5'd6; sb_if.write_fu[1] = 3'd2; sb_if.write_pos[1] = 5'b00001;
    step(); idle(); sb_if.stall = 1'b1; sb_if.kill_mask = 5'b11000;
    step(); idle(); sb_if.read_addr[0] = 5'd4; sb_if.read_addr[1] = 5'd6; #1;
    chk("t4 killed", sb_if.read_pending[0], 0);
    chk("t4 kept", sb_if.read_pos[1], 5'b00001);
    chk("t4 busy", sb_if.busy_count, 1);
    sb_if.flash = 1'b1;
    step(); idle();

    // Bypass and register zero.
    sb_if.write_ena = 2'b11;
    sb_if.write_addr[0] = 5'd9; sb_if.write_fu[0] = 3'd6; sb_if.write_pos[0] = 5'b00100;
    sb_if.write_addr[1] = 5'd0; sb_if.write_fu[1] = 3'd3; sb_if.write_pos[1] = 5'b10000;
    sb_if.read_addr[0] = 5'd9; sb_if.read_addr[1] = 5'd0; #1;
    chk("t5 bypass pos", sb_if.read_pos[0], 5'b00100);
    chk("t5 bypass stall", sb_if.read_stall[0], 1);
    chk("t5 r0 pending", sb_if.read_pending[1], 0);
    step(); idle(); #1;
    chk("t5 busy", sb_if.busy_count, 1);
    sb_if.flash = 1'b1;
    step(); idle();

    // Asynchronous reset with four results in flight.
    sb_if.write_ena = 2'b11;
    sb_if.write_addr[0] = 5'd10; sb_if.write_fu[0] = 3'd1; sb_if.write_pos[0] = 5'b10000;
    sb_if.write_addr[1] = 5'd11; sb_if.write_fu[1] = 3'd2; sb_if.write_pos[1] = 5'b10000;
    step();
    sb_if.write_addr[0] = 5'd12; sb_if.write_addr[1] = 5'd13;
    step(); idle();
    for (int p = 0; p < RP; p++) sb_if.read_addr[p] = 5'(10 + p);
    #1;
    chk("t6 busy before", sb_if.busy_count, 4);
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int p = 0; p < RP; p++) chk("t6 reset pending", sb_if.read_pending[p], 0);
    chk("t6 reset busy", sb_if.busy_count, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    sb_if.write_ena[0] = 1'b1; sb_if.write_addr[0] = 5'd20;
    sb_if.write_fu[0] = 3'd7;  sb_if.write_pos[0] = 5'b10000;
    step(); idle(); sb_if.read_addr[0] = 5'd20; #1;
    chk("t6 post pos", sb_if.read_pos[0], 5'b10000);
    chk("t6 post busy", sb_if.busy_count, 1);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      idle();
      rst_n = 1'b1;
      sb_if.stall = ($urandom_range(0, 99) < 20);
      if ($urandom_range(0, 99) < 5) sb_if.kill_mask = 5'($urandom_range(1, 31));
      sb_if.flash = ($urandom_range(0, 99) < 3);
      for (int s = 0; s < WP; s++) begin
        sb_if.write_ena[s]  = ($urandom_range(0, 99) < 60);
        sb_if.write_addr[s] = 5'($urandom_range(0, 15));
        sb_if.write_fu[s]   = 3'($urandom);
        if ($urandom_range(0, 9) < 8) sb_if.write_pos[s] = 5'(1 << $urandom_range(0, 4));
        else                          sb_if.write_pos[s] = 5'($urandom);
      end
      for (int p = 0; p < RP; p++) begin
        if ($urandom_range(0, 1) == 1) sb_if.read_addr[p] = sb_if.write_addr[$urandom_range(0, WP-1)];
        else                           sb_if.read_addr[p] = 5'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 99) < 1) begin
        rst_n = 1'b0;
        model_reset();
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/score_board_mp.md
# score_board_mp

Parametrised multi-port register scoreboard for the issue stage. It tracks, per architectural register, which functional unit will produce the pending result and how far that result is from writeback, as a one-hot position field shifted right once per advancing cycle. It generalises the fixed 2-write/4-read scoreboard in three ways:
- configurable port counts and depth;
- selective stage kill for partial pipeline flushes;
- a per-read-port RAW-stall decision with a configurable forwarding mask.

## Interface
Parameters:
- REG_NUM, 32: architectural registers. Power of two. Register 0 is hard-wired to zero.
- WRITE_PORTS, 2: issue slots that may claim a destination per cycle.
- READ_PORTS, 4: source-operand lookups per cycle.
- POS_W, 5: width of the position field. Bit k set means the result is k+1 advancing cycles from writeback.
- FU_W, 3: width of the functional-unit tag.
- FWD_MASK, 5'b00011: position bits whose result is forwardable. A pending source whose position lies only in these bits does not stall.
- BYPASS, 1: if 1, reads see same-cycle writes.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  freeze: no shift and no write.
- flash  in  1  full flush: clear all entries.
- kill_mask  in  POS_W  partial flush: clear entries whose position intersects the mask.
- write_ena  in  WRITE_PORTS  per-slot claim enable.
- write_addr  in  WRITE_PORTS×log2(REG_NUM)  destination register per slot.
- write_fu  in  WRITE_PORTS×FU_W  producing unit per slot.
- write_pos  in  WRITE_PORTS×POS_W  initial one-hot position per slot.
- read_addr  in  READ_PORTS×log2(REG_NUM)  source registers.
- read_fu  out  READ_PORTS×FU_W  producing unit of each source.
- read_pos  out  READ_PORTS×POS_W  current position of each source.
- read_pending  out  READ_PORTS  position is not zero.
- read_stall  out  READ_PORTS  (position & ~FWD_MASK) is not zero.
- busy_count  out  log2(REG_NUM)+1  number of entries with nonzero position. Registered.

## Operation
- Entry = {fu, pos}. An entry is pending iff pos is not zero.
- Priority per cycle is rst_n, then flash, then kill_mask, then stall, then normal update. Kill and flush act even while stall is high.
- flash: every entry becomes {0,0}.
- kill_mask not zero and flash low: an entry with (pos & kill_mask) not zero becomes {0,0}. Every other entry holds when stall is high, otherwise shifts. No writes are accepted that cycle.
- Normal update (stall low, no flush, no kill):
  - Each entry's pos shifts right by 1. fu holds. An entry reaching 0 is free.
  - For each enabled slot with write_addr not 0, the entry is loaded with {write_fu, write_pos} instead of shifting.
  - If two slots hit the same address, the higher slot index wins.
  - Writes to register 0 are ignored.
- Reads are combinational from the stored entries, with these overrides:
  - Register 0 always reads {0,0}, not pending, no stall.
  - BYPASS=1 and a normal update in progress: a read matching an enabled write slot returns that slot's {fu, pos}, highest slot wins. This is the un-shifted value the entry will hold next cycle.
- busy_count is the registered population count of pending entries after the update.

## Timing
- Reset (rst_n low, asynchronous): all entries {0,0} and busy_count 0 immediately. All read outputs are therefore 0.
- A write becomes visible in stored state 1 cycle later, or 0 cycles later with BYPASS=1.
- A result with write_pos = 1<<k clears after exactly k+1 non-stalled cycles.
- Stall cycles extend this one-for-one.
- A kill takes effect at the next edge. Shifting resumes the cycle after.
- Deasserting rst_n mid-operation with writes present: the first edge after release performs a normal update from the all-clear state.

## Structure
- Shared package, added to defines.svh:
  - SB_POS_W, SB_FU_W, SB_FWD_MASK default constants;
  - sb_entry_t packed struct {fu, pos} at the default widths, used when the parameters equal the defaults;
  - the bool type and `true/`false already defined there.
- Sub-module sb_entry holds one entry and its shift/load/kill logic. It has inputs for shift enable, load, load data, clear and kill_mask. score_board_mp instantiates REG_NUM−1 of them (entry 0 is constant).

## Test plan
- Reset then idle: write r5 with fu=2, pos=5'b10000. read_pending(r5) is 1 for 5 cycles, then 0. read_stall drops when pos reaches 5'b00010.
- Same-address write: slot0 r7 fu=1, slot1 r7 fu=4, same cycle. r7 reads fu=4. busy_count=1.
- Stall: write r3 pos=5'b00100, then stall for 3 cycles. pos holds 5'b00100, then clears 3 cycles after stall drops.
- Kill while stalled: r4 pos=5'b01000, r6 pos=5'b00001, kill_mask=5'b11000 with stall=1. r4 is cleared, r6 is kept. busy_count=1.
- BYPASS=1: write r9 pos=5'b00100 and read r9 in the same cycle. read_pos is 5'b00100 and read_stall is 1. Writing r0 reads not pending.
- Async reset mid-flight with 4 pending entries: outputs go to 0 before the next clk edge. busy_count=0.
